// File: rtl/seg_pkg.sv
// Shared types and default scan-rate constants for the seven-segment scan scheduler
// and its phase-accumulator tick source.
package seg_pkg;

  localparam int unsigned SEG_ACC_W = 32;
  localparam logic [31:0] SEG_STEP  = 32'd90000;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/phase_tick_gen.sv
// Phase-accumulator rate generator: emits a one-cycle tick on every accumulator carry.
// The accumulator wraps modulo 2^ACC_W and holds while en is low.
module phase_tick_gen
  import seg_pkg::*;
#(
  parameter int               ACC_W = SEG_ACC_W,
  parameter logic [ACC_W-1:0] STEP  = ACC_W'(SEG_STEP)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;

  assign sum  = {1'b0, acc_q} + {1'b0, STEP};
  assign tick = sum[ACC_W] & en;

  always_comb begin
    acc_d = acc_q;
    if (en) acc_d = sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

endmodule

// File: rtl/seg_mux_scheduler.sv
// Multiplexed seven-segment scan: one shared decoder, per-digit active-low anodes,
// with a blanking interval before each digit so the decoder settles before lighting.
//
// state | meaning
// BLANK | all anodes off; nibble_out settling; frame data captured while on digit 0
// ON    | anode of digit_idx driven low for DWELL_TICKS ticks
module seg_mux_scheduler
  import seg_pkg::*;
#(
  parameter int               N_DIGITS    = 2,
  parameter int               ACC_W       = SEG_ACC_W,
  parameter logic [ACC_W-1:0] STEP        = ACC_W'(SEG_STEP),
  parameter int               DWELL_TICKS = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic [4*N_DIGITS-1:0]       digits_in,
  output logic [3:0]                  nibble_out,
  output logic [N_DIGITS-1:0]         anode_n,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_start
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int DW_W  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);
  localparam logic [DW_W-1:0]  LAST_DWELL = DW_W'(DWELL_TICKS - 1);

  logic tick;

  phase_tick_gen #(
    .ACC_W (ACC_W),
    .STEP  (STEP)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .tick    (tick)
  );

  scan_state_t           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW_W-1:0]       dwell_q, dwell_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [N_DIGITS-1:0]   anode_q, anode_d;
  logic                  fs_q, fs_d;
  nibble_t               nib_q, nib_d;
  logic [N_DIGITS-1:0]   lit_mask;

  assign lit_mask = ~(N_DIGITS'(1) << idx_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dwell_d  = dwell_q;
    shadow_d = shadow_q;
    anode_d  = '1;
    fs_d     = 1'b0;
    if (en) begin
      case (state_q)
        BLANK: begin
          if (tick) begin
            state_d = ON;
            dwell_d = '0;
            anode_d = lit_mask;
            fs_d    = (idx_q == '0);
          end else if (idx_q == '0) begin
            // Latch the whole frame before digit 0 lights so later input edits cannot tear it.
            shadow_d = digits_in;
          end
        end
        ON: begin
          if (tick && (dwell_q == LAST_DWELL)) begin
            state_d = BLANK;
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          end else begin
            anode_d = lit_mask;
            if (tick) dwell_d = dwell_q + DW_W'(1);
          end
        end
        default: state_d = BLANK;
      endcase
    end
    nib_d = shadow_d[{idx_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= BLANK;
      idx_q    <= '0;
      dwell_q  <= '0;
      shadow_q <= '0;
      anode_q  <= '1;
      fs_q     <= 1'b0;
      nib_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dwell_q  <= dwell_d;
      shadow_q <= shadow_d;
      anode_q  <= anode_d;
      fs_q     <= fs_d;
      nib_q    <= nib_d;
    end
  end

  assign nibble_out  = nib_q;
  assign anode_n     = anode_q;
  assign digit_idx   = idx_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// Bench for seg_mux_scheduler: 2 digits, tick every 4 clks, 2 ticks of dwell,
// so one frame is 24 clks; a second instance runs with a zero step.
module tb_seg_mux_scheduler;

  typedef struct packed {
    logic [1:0] anode;
    logic [3:0] nib;
    logic       idx;
    logic       fs;
  } exp_t;

  typedef struct {
    int         edge_k;
    logic [7:0] digits;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] digits_in = 8'h3A;
  logic [3:0] nibble_out;
  logic [1:0] anode_n;
  logic [0:0] digit_idx;
  logic       frame_start;

  logic       z_en = 1'b1;
  logic [3:0] z_nibble_out;
  logic [1:0] z_anode_n;
  logic [0:0] z_digit_idx;
  logic       z_frame_start;

  int         total = 0;
  int         bad = 0;
  int         k = 0;
  logic [7:0] sh_m = 8'h00;
  exp_t       sb[$];
  bit         zchk = 1'b0;
  logic       en_prev;
  vec_t       vecs[10];

  always #5 clk = ~clk;

  seg_mux_scheduler #(
    .N_DIGITS(2), .ACC_W(4), .STEP(4'd4), .DWELL_TICKS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .digits_in(digits_in),
    .nibble_out(nibble_out), .anode_n(anode_n), .digit_idx(digit_idx),
    .frame_start(frame_start)
  );

  seg_mux_scheduler #(
    .N_DIGITS(2), .ACC_W(4), .STEP(4'd0), .DWELL_TICKS(2)
  ) dut_z (
    .clk(clk), .reset_n(reset_n), .en(z_en), .digits_in(digits_in),
    .nibble_out(z_nibble_out), .anode_n(z_anode_n), .digit_idx(z_digit_idx),
    .frame_start(z_frame_start)
  );

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s k=%0d act=%0h exp=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic check_exp(input string tag, input exp_t e);
    cmp({tag, ".anode_n"},     int'(anode_n),     int'(e.anode));
    cmp({tag, ".nibble_out"},  int'(nibble_out),  int'(e.nib));
    cmp({tag, ".digit_idx"},   int'(digit_idx),   int'(e.idx));
    cmp({tag, ".frame_start"}, int'(frame_start), int'(e.fs));
  endtask

  // Expected outputs after the k-th enabled edge since reset release, free-running scan.
  function automatic exp_t model(input int kk, input logic [7:0] sh);
    exp_t e;
    int   m;
    m = kk % 24;
    e.fs = (m == 4);
    if (m < 4)       begin e.anode = 2'b11; e.idx = 1'b0; end
    else if (m < 12) begin e.anode = 2'b10; e.idx = 1'b0; end
    else if (m < 16) begin e.anode = 2'b11; e.idx = 1'b1; end
    else             begin e.anode = 2'b01; e.idx = 1'b1; end
    e.nib = e.idx ? sh[7:4] : sh[3:0];
    return e;
  endfunction

  task automatic push_next();
    k++;
    if ((k % 24) inside {[1:3]}) sh_m = digits_in;
    sb.push_back(model(k, sh_m));
  endtask

  task automatic edge_wait();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    push_next();
    edge_wait();
    check_exp("scan", sb.pop_front());
  endtask

  always @(negedge clk) begin
    if (zchk) begin
      total++;
      if (z_anode_n !== 2'b11 || z_frame_start !== 1'b0) begin
        bad++;
        $display("FAIL zero_step anode_n=%b frame_start=%b exp 11/0", z_anode_n, z_frame_start);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1,  8'h3A, '{2'b11, 4'hA, 1'b0, 1'b0}};
    vecs[1] = '{4,  8'h3A, '{2'b10, 4'hA, 1'b0, 1'b1}};
    vecs[2] = '{5,  8'h3A, '{2'b10, 4'hA, 1'b0, 1'b0}};
    vecs[3] = '{11, 8'h3A, '{2'b10, 4'hA, 1'b0, 1'b0}};
    vecs[4] = '{12, 8'h3A, '{2'b11, 4'h3, 1'b1, 1'b0}};
    vecs[5] = '{15, 8'h3A, '{2'b11, 4'h3, 1'b1, 1'b0}};
    vecs[6] = '{16, 8'h3A, '{2'b01, 4'h3, 1'b1, 1'b0}};
    vecs[7] = '{23, 8'h3A, '{2'b01, 4'h3, 1'b1, 1'b0}};
    vecs[8] = '{24, 8'h3A, '{2'b11, 4'hA, 1'b0, 1'b0}};
    vecs[9] = '{28, 8'h3A, '{2'b10, 4'hA, 1'b0, 1'b1}};

    repeat (2) edge_wait();
    check_exp("reset", '{2'b11, 4'h0, 1'b0, 1'b0});
    reset_n = 1'b1;
    zchk    = 1'b1;

    // Default-rate first frame from the hand table
    for (int i = 0; i < 10; i++) begin
      digits_in = vecs[i].digits;
      while (k < vecs[i].edge_k - 1) step();
      push_next();
      void'(sb.pop_back());
      sb.push_back(vecs[i].e);
      edge_wait();
      check_exp("vec", sb.pop_front());
    end

    // Change data while digit 1 is lit: current frame keeps 3, next shows C then 5
    while (k < 40) step();
    digits_in = 8'h5C;
    while (k < 77) step();

    // Freeze in ON (digit 0, dwell 0) for 10 edges
    en = 1'b0;
    repeat (10) begin
      edge_wait();
      check_exp("freeze", '{2'b11, 4'hC, 1'b0, 1'b0});
    end
    en = 1'b1;
    repeat (6) begin
      edge_wait();
      check_exp("relight", '{2'b10, 4'hC, 1'b0, 1'b0});
    end
    edge_wait();
    check_exp("relight_done", '{2'b11, 4'h5, 1'b1, 1'b0});
    repeat (3) begin
      edge_wait();
      check_exp("blank_d1", '{2'b11, 4'h5, 1'b1, 1'b0});
    end
    repeat (2) begin
      edge_wait();
      check_exp("lit_d1", '{2'b01, 4'h5, 1'b1, 1'b0});
    end

    // Single-cycle reset while digit 1 is lit, then scan restarts from BLANK
    reset_n = 1'b0;
    edge_wait();
    check_exp("reset_mid", '{2'b11, 4'h0, 1'b0, 1'b0});
    reset_n = 1'b1;
    k    = 0;
    sh_m = 8'h00;
    sb.delete();
    repeat (30) step();

    // Random data and enable: one anode at most, none right after a disabled edge
    for (int i = 0; i < 10000; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      digits_in = 8'($urandom);
      en_prev   = en;
      edge_wait();
      cmp("mutex", int'($countones(~anode_n) <= 1), 1);
      if (!en_prev) cmp("en_off_dark", int'(anode_n), 3);
    end

    zchk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_mux_scheduler.md
Name: seg_mux_scheduler

Overview:
- Time-multiplexes N seven-segment digits onto one shared segment decoder.
- Generates its own scan rate from the system clock with a phase accumulator.
- Sequences the digits, driving the decoder's nibble input and the per-digit active-low anode enables.
- Inserts a blanking tick before each digit so the shared decoder settles before the anode turns on (no ghosting).

Parameters:
- N_DIGITS, 2, number of multiplexed digits (≥2).
- ACC_W, 32, phase accumulator width.
- STEP, 32'd90000, accumulator increment per clk; scan tick rate = f_clk*STEP/2^ACC_W.
- DWELL_TICKS, 4, ticks a digit stays lit per visit (≥1).

Ports:
- clk  input  1  system clock (HSOSC-derived).
- reset_n  input  1  synchronous reset, active-low.
- en  input  1  scan enable; low freezes the scan and blanks all anodes.
- digits_in  input  4*N_DIGITS  nibble for digit i in bits [4i+3:4i].
- nibble_out  output  4  value to the shared segment decoder.
- anode_n  output  N_DIGITS  active-low digit enables; at most one low at any time.
- digit_idx  output  $clog2(N_DIGITS)  index of the digit currently selected.
- frame_start  output  1  one-cycle pulse when digit 0 is lit at the start of a frame.

Behaviour:
- Reset is synchronous, active-low, and applies on any clk edge with reset_n=0, including mid-scan. Reset values:
  - acc=0, state=BLANK, digit_idx=0, dwell_cnt=0, shadow=0
  - anode_n all 1, frame_start=0, nibble_out=0
- Tick:
  - {carry, acc_next} = acc + STEP, ACC_W+1-bit sum; acc <= acc_next when en=1.
  - tick = carry & en. The FSM acts on the same edge.
  - STEP=0 means no ticks ever; the block stays in BLANK with anodes off.
- States:
  - BLANK: anode_n all 1.
    - On tick: go to ON, dwell_cnt <= 0, anode_n[digit_idx] <= 0.
    - If digit_idx==0, frame_start <= 1 for exactly that one cycle.
  - ON: anode_n[digit_idx] = 0, all others 1.
    - On tick with dwell_cnt < DWELL_TICKS-1: dwell_cnt++.
    - On tick with dwell_cnt == DWELL_TICKS-1: go to BLANK, anode_n all 1, digit_idx <= (digit_idx == N_DIGITS-1) ? 0 : digit_idx+1.
- Shadow capture:
  - shadow <= digits_in on every enabled edge where state==BLANK, digit_idx==0 and tick==0.
  - This freezes frame data at least one cycle before digit 0 lights. digits_in changes mid-frame never tear a frame.
- nibble_out = shadow[4*digit_idx +: 4]. It is driven from registers only and changes only while state==BLANK or on the ON→BLANK edge.
- en=0:
  - acc, state, digit_idx, dwell_cnt and shadow hold.
  - anode_n <= all 1 on the next edge.
  - When en returns high in ON, the held anode is re-asserted on the next edge and the dwell count continues.
- anode_n, frame_start and digit_idx are registered outputs; they never glitch.
- Accumulator wrap is modular, with no saturation.

Decomposition:
- Shared package seg_pkg:
  - typedef scan_state_t enum {BLANK, ON}
  - localparam default STEP value and ACC_W
  - typedef nibble_t logic[3:0]
- One sub-module, phase_tick_gen:
  - Parameters ACC_W and STEP; ports clk, reset_n, en, tick.
  - Reusable by the existing divider logic.
- The FSM, shadow register and muxing stay in seg_mux_scheduler.

Test Plan:
- Default tick rate: ACC_W=4, STEP=4, DWELL_TICKS=2, N_DIGITS=2, en=1, digits_in=8'h3A → tick every 4 clks; sequence is BLANK(4) → anode_n=2'b10 for 8 clks with nibble_out=A → BLANK(4) → anode_n=2'b01 for 8 clks with nibble_out=3; frame_start high exactly once per 24 clks.
- Mid-frame tear: same setup, change digits_in to 8'h5C while digit 1 is lit → digit 1 still shows 3; next frame shows C then 5.
- Mutual exclusion: random digits_in and random en toggling for 10k cycles → $countones(~anode_n) ≤ 1 always; no anode low while en was low on the previous edge.
- Enable freeze: drop en for 10 clks while in ON → anode_n=all 1 from the next edge; after en returns high, the same digit relights and completes its remaining dwell ticks.
- Reset mid-scan: assert reset_n=0 for 1 clk while digit 1 is lit → next cycle anode_n=all 1, digit_idx=0, nibble_out=0; the scan restarts from BLANK.
- Zero step: STEP=0 → anode_n stays all 1 and frame_start stays 0 for 1000 clks.
